focus_sharpness_stat: RTL and testbench



---
 rtl/focus_sharpness_stat.sv | 205 ++++++++++++++++++++
 tb/tb_focus_sharpness_stat.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/focus_sharpness_stat.sv
// focus_sharpness_stat: per-frame auto-focus sharpness score from thresholded luma gradients.
// Optional macro VERT_GRAD_EN adds a line-buffered vertical gradient term. Rev 1.0
`default_nettype none

module focus_sharpness_stat #(
   parameter int H_ACTIVE = 640,
   parameter int WIN_X0   = 160,
   parameter int WIN_X1   = 480,
   parameter int WIN_Y0   = 120,
   parameter int WIN_Y1   = 360,
   parameter int THRESH   = 8,
   parameter int SUM_W    = 32
) (
   input  logic             VIDEO_CLK,
   input  logic             RESET,
   input  logic             VIDEO_VS,
   input  logic             VIDEO_HS,
   input  logic             VIDEO_DE,
   input  logic [7:0]       iR,
   input  logic [7:0]       iG,
   input  logic [7:0]       iB,
   input  logic             FULL_WIN,
   output logic [SUM_W-1:0] SCORE,
   output logic [19:0]      WIN_PIX,
   output logic             SCORE_VALID,
   output logic             IN_WIN
);

   localparam logic [11:0] c_WIN_X0 = 12'(WIN_X0);
   localparam logic [11:0] c_WIN_X1 = 12'(WIN_X1);
   localparam logic [11:0] c_WIN_Y0 = 12'(WIN_Y0);
   localparam logic [11:0] c_WIN_Y1 = 12'(WIN_Y1);
   localparam logic [7:0]  c_THRESH = 8'(THRESH);
   localparam logic [11:0] c_CNT_MAX = 12'hFFF;

   // Input edge detectors and pixel/line counters
   logic        r_hs_d, r_vs_d, r_de_d;
   logic [11:0] r_h_cnt, r_v_cnt;
   logic        w_hs_fall, w_vs_fall, w_de_fall;
   logic [11:0] w_h_idx;
   logic [15:0] w_luma;
   logic [7:0]  w_y;

   assign w_hs_fall = r_hs_d & ~VIDEO_HS;
   assign w_vs_fall = r_vs_d & ~VIDEO_VS;
   assign w_de_fall = r_de_d & ~VIDEO_DE;
   assign w_h_idx   = w_hs_fall ? 12'd0 : r_h_cnt;
   assign w_luma    = ({8'd0, iR} * 16'd77) + ({8'd0, iG} * 16'd150) + ({8'd0, iB} * 16'd29);
   assign w_y       = 8'(w_luma >> 8);

   always_ff @(posedge VIDEO_CLK or posedge RESET) begin
      if (RESET) begin
         r_hs_d  <= 1'b0;
         r_vs_d  <= 1'b0;
         r_de_d  <= 1'b0;
         r_h_cnt <= 12'd0;
         r_v_cnt <= 12'd0;
      end else begin
         r_hs_d <= VIDEO_HS;
         r_vs_d <= VIDEO_VS;
         r_de_d <= VIDEO_DE;
         if (VIDEO_DE && (w_h_idx != c_CNT_MAX))
            r_h_cnt <= w_h_idx + 12'd1;
         else
            r_h_cnt <= w_h_idx;
         if (w_vs_fall)
            r_v_cnt <= 12'd0;
         else if (w_de_fall && (r_v_cnt != c_CNT_MAX))
            r_v_cnt <= r_v_cnt + 12'd1;
      end
   end

   // Stage 1: luma plus the coordinates of the pixel it came from
   logic [7:0]  r_y1;
   logic        r_de1;
   logic [11:0] r_h1, r_v1;

   always_ff @(posedge VIDEO_CLK or posedge RESET) begin
      if (RESET) begin
         r_y1  <= 8'd0;
         r_de1 <= 1'b0;
         r_h1  <= 12'd0;
         r_v1  <= 12'd0;
      end else begin
         r_y1  <= w_y;
         r_de1 <= VIDEO_DE;
         r_h1  <= w_h_idx;
         r_v1  <= r_v_cnt;
      end
   end

   // Stage 2: horizontal gradient and window membership
   logic [7:0] r_yprev, r_grad;
   logic       r_in_win, r_de2;
   logic [7:0] w_hdiff;
   logic       w_win;

   assign w_hdiff = (r_y1 >= r_yprev) ? (r_y1 - r_yprev) : (r_yprev - r_y1);
   assign w_win   = FULL_WIN ||
                    ((r_h1 >= c_WIN_X0) && (r_h1 < c_WIN_X1) &&
                     (r_v1 >= c_WIN_Y0) && (r_v1 < c_WIN_Y1));

   always_ff @(posedge VIDEO_CLK or posedge RESET) begin
      if (RESET) begin
         r_yprev  <= 8'd0;
         r_grad   <= 8'd0;
         r_in_win <= 1'b0;
         r_de2    <= 1'b0;
      end else begin
         if (r_de1)
            r_yprev <= r_y1;
         r_grad   <= (r_h1 == 12'd0) ? 8'd0 : w_hdiff;
         r_in_win <= w_win;
         r_de2    <= r_de1;
      end
   end

   assign IN_WIN = r_de2 & r_in_win;

   logic [8:0] w_hterm, w_term;
   assign w_hterm = (r_grad >= c_THRESH) ? {1'b0, r_grad} : 9'd0;

`ifdef VERT_GRAD_EN
   localparam int          c_AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam logic [11:0] c_HA = 12'(H_ACTIVE);

   logic [7:0] r_lbuf [0:H_ACTIVE-1];
   logic [7:0] r_yabove, r_vgrad;
   logic [7:0] w_vdiff;
   logic [8:0] w_vterm;

   // Read issued alongside stage 1 so Y_above lines up with r_y1; write lags by one pixel
   always_ff @(posedge VIDEO_CLK) begin
      if (w_h_idx < c_HA)
         r_yabove <= r_lbuf[w_h_idx[c_AW-1:0]];
      if (r_de1 && (r_h1 < c_HA))
         r_lbuf[r_h1[c_AW-1:0]] <= r_y1;
   end

   assign w_vdiff = (r_y1 >= r_yabove) ? (r_y1 - r_yabove) : (r_yabove - r_y1);

   always_ff @(posedge VIDEO_CLK or posedge RESET) begin
      if (RESET)
         r_vgrad <= 8'd0;
      else
         r_vgrad <= (r_v1 == 12'd0) ? 8'd0 : w_vdiff;
   end

   assign w_vterm = (r_vgrad >= c_THRESH) ? {1'b0, r_vgrad} : 9'd0;
   assign w_term  = w_hterm + w_vterm;
`else
   assign w_term  = w_hterm;
`endif

   // Accumulation and frame latch
   logic [SUM_W-1:0] r_acc;
   logic [19:0]      r_pix;
   logic             r_vs_fall, r_first;
   logic             w_hit;
   logic [8:0]       w_add;
   logic [SUM_W:0]   w_sum;
   logic [SUM_W-1:0] w_acc_sat, w_add_ext;
   logic [19:0]      w_pix_next;

   assign w_hit      = r_de2 & r_in_win;
   assign w_add      = w_hit ? w_term : 9'd0;
   assign w_add_ext  = {{(SUM_W-9){1'b0}}, w_add};
   assign w_sum      = {1'b0, r_acc} + {1'b0, w_add_ext};
   assign w_acc_sat  = w_sum[SUM_W] ? {SUM_W{1'b1}} : w_sum[SUM_W-1:0];
   assign w_pix_next = (w_hit && (r_pix != 20'hFFFFF)) ? (r_pix + 20'd1) : r_pix;

   // A pixel arriving on the latch cycle seeds the new frame's totals
   always_ff @(posedge VIDEO_CLK or posedge RESET) begin
      if (RESET) begin
         r_vs_fall   <= 1'b0;
         r_first     <= 1'b1;
         r_acc       <= '0;
         r_pix       <= 20'd0;
         SCORE       <= '0;
         WIN_PIX     <= 20'd0;
         SCORE_VALID <= 1'b0;
      end else begin
         r_vs_fall <= w_vs_fall;
         if (r_vs_fall) begin
            if (!r_first) begin
               SCORE       <= r_acc;
               WIN_PIX     <= r_pix;
               SCORE_VALID <= 1'b1;
            end else begin
               SCORE_VALID <= 1'b0;
            end
            r_first <= 1'b0;
            r_acc   <= w_add_ext;
            r_pix   <= {19'd0, w_hit};
         end else begin
            SCORE_VALID <= 1'b0;
            r_acc       <= w_acc_sat;
            r_pix       <= w_pix_next;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_focus_sharpness_stat.sv
// tb_focus_sharpness_stat: directed frames on a 16x8 raster, two instances (SUM_W 32 and 12).
// Expected scores follow the VERT_GRAD_EN macro when it is defined. Rev 1.0
`default_nettype none

module tb_focus_sharpness_stat;

   logic        clk = 1'b0;
   logic        rst, vs, hs, de, full;
   logic [7:0]  r, g, b;
   logic [31:0] score_a;
   logic [11:0] score_b;
   logic [19:0] pix_a, pix_b;
   logic        val_a, val_b, inw_a, inw_b;

   int vectors     = 0;
   int miscompares = 0;
   int inwin_cnt   = 0;

   always #5 clk = ~clk;

   focus_sharpness_stat #(
      .H_ACTIVE(16), .WIN_X0(4), .WIN_X1(12), .WIN_Y0(2), .WIN_Y1(6), .THRESH(8), .SUM_W(32)
   ) u_dut_a (
      .VIDEO_CLK(clk), .RESET(rst), .VIDEO_VS(vs), .VIDEO_HS(hs), .VIDEO_DE(de),
      .iR(r), .iG(g), .iB(b), .FULL_WIN(full),
      .SCORE(score_a), .WIN_PIX(pix_a), .SCORE_VALID(val_a), .IN_WIN(inw_a)
   );

   focus_sharpness_stat #(
      .H_ACTIVE(16), .WIN_X0(4), .WIN_X1(12), .WIN_Y0(2), .WIN_Y1(6), .THRESH(8), .SUM_W(12)
   ) u_dut_b (
      .VIDEO_CLK(clk), .RESET(rst), .VIDEO_VS(vs), .VIDEO_HS(hs), .VIDEO_DE(de),
      .iR(r), .iG(g), .iB(b), .FULL_WIN(full),
      .SCORE(score_b), .WIN_PIX(pix_b), .SCORE_VALID(val_b), .IN_WIN(inw_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      if (inw_a) inwin_cnt++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // mode 0 flat ca, 1 column stripes ca/cb, 2 row stripes ca/cb
   task automatic line(input int mode, input logic [23:0] ca, input logic [23:0] cb, input int ln);
      logic [23:0] px;
      hs = 1'b0; tick(); tick();
      hs = 1'b1; tick(); tick();
      for (int h = 0; h < 16; h++) begin
         if (mode == 1)      px = (h % 2 == 1) ? cb : ca;
         else if (mode == 2) px = (ln % 2 == 1) ? cb : ca;
         else                px = ca;
         de = 1'b1;
         {r, g, b} = px;
         tick();
      end
      de = 1'b0;
      {r, g, b} = 24'd0;
      tick(); tick(); tick();
   endtask

   task automatic frame(input int mode, input logic [23:0] ca, input logic [23:0] cb,
                        input int l0, input int l1);
      for (int ln = l0; ln < l1; ln++) line(mode, ca, cb, ln);
      for (int i = 0; i < 6; i++) tick();
   endtask

   task automatic vs_pulse(input string tag, input logic exp_v, input logic [31:0] ea,
                           input logic [31:0] eb, input logic [31:0] ep);
      vs = 1'b0;
      tick();
      check({tag, "_valid_early"}, {31'd0, val_a}, 32'd0);
      tick();
      check({tag, "_valid_a"}, {31'd0, val_a}, {31'd0, exp_v});
      check({tag, "_valid_b"}, {31'd0, val_b}, {31'd0, exp_v});
      check({tag, "_score_a"}, score_a, ea);
      check({tag, "_score_b"}, {20'd0, score_b}, eb);
      check({tag, "_winpix_a"}, {12'd0, pix_a}, ep);
      check({tag, "_winpix_b"}, {12'd0, pix_b}, ep);
      vs = 1'b1;
      tick();
      check({tag, "_valid_late"}, {31'd0, val_a}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; vs = 1'b1; hs = 1'b1; de = 1'b0; full = 1'b0;
      r = 8'd0; g = 8'd0; b = 8'd0;
      tick(); tick(); tick();
      check("rst_score", score_a, 32'd0);
      check("rst_winpix", {12'd0, pix_a}, 32'd0);
      check("rst_valid", {31'd0, val_a}, 32'd0);
      check("rst_inwin", {31'd0, inw_a}, 32'd0);
      rst = 1'b0;
      tick(); tick();

      // First VS after reset only arms the accumulators
      vs_pulse("first_vs", 1'b0, 32'd0, 32'd0, 32'd0);

      frame(0, 24'h808080, 24'h808080, 0, 8);
      vs_pulse("flat", 1'b1, 32'd0, 32'd0, 32'd32);

      inwin_cnt = 0;
      frame(1, 24'h000000, 24'hFFFFFF, 0, 8);
      check("inwin_window", inwin_cnt, 32'd32);
      vs_pulse("stripe", 1'b1, 32'd8160, 32'd4095, 32'd32);

      frame(1, 24'h808080, 24'h868686, 0, 8);
      vs_pulse("below_thr", 1'b1, 32'd0, 32'd0, 32'd32);

      frame(1, 24'h808080, 24'h888888, 0, 8);
      vs_pulse("at_thr", 1'b1, 32'd256, 32'd256, 32'd32);

      full = 1'b1;
      inwin_cnt = 0;
      frame(1, 24'h000000, 24'hFFFFFF, 0, 8);
      full = 1'b0;
      check("inwin_full", inwin_cnt, 32'd128);
      vs_pulse("full_win", 1'b1, 32'd30600, 32'd4095, 32'd128);

      // Red vs black: Y = 76; green vs blue: Y = 149 vs 28
      frame(1, 24'h000000, 24'hFF0000, 0, 8);
      vs_pulse("red", 1'b1, 32'd2432, 32'd2432, 32'd32);

      frame(1, 24'h00FF00, 24'h0000FF, 0, 8);
      vs_pulse("grn_blu", 1'b1, 32'd3872, 32'd3872, 32'd32);

      frame(2, 24'h000000, 24'hFFFFFF, 0, 8);
`ifdef VERT_GRAD_EN
      vs_pulse("rows", 1'b1, 32'd8160, 32'd4095, 32'd32);
`else
      vs_pulse("rows", 1'b1, 32'd0, 32'd0, 32'd32);
`endif

      // Reset in the middle of a frame discards it and re-arms first-frame suppression
      frame(1, 24'h000000, 24'hFFFFFF, 0, 4);
      rst = 1'b1;
      tick(); tick();
      check("midrst_score", score_a, 32'd0);
      check("midrst_winpix", {12'd0, pix_a}, 32'd0);
      rst = 1'b0;
      frame(1, 24'h000000, 24'hFFFFFF, 4, 8);
      vs_pulse("after_rst", 1'b0, 32'd0, 32'd0, 32'd0);

      frame(1, 24'h000000, 24'hFFFFFF, 0, 8);
      vs_pulse("recover", 1'b1, 32'd8160, 32'd4095, 32'd32);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
